// File: rtl/instr_sequencer.sv
// instr_sequencer: FETCH/DECODE/EXEC/WB control sequencer for the 16-bit core.
// Optional build macro ILLEGAL_TRAP_EN: illegal instructions halt the core instead of running as NOPs.
`default_nettype none

module instr_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      rd_addr,
  output logic [2:0]      rs_addr,
  output logic [3:0]      ALUop,
  output logic            regWrite,
  output logic            muxWriteReg,
  output logic            muxWriteData,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_AR   = 5'b00010;
  localparam logic [4:0] OP_T    = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t      state;
  logic [15:0] ir;
  logic        wr_en;

  logic is_ar, is_t, is_halt, is_legal;
  logic unused_ir_bit4;

  assign is_ar    = (ir[15:11] == OP_AR);
  assign is_t     = (ir[15:11] == OP_T);
  assign is_halt  = (ir[15:11] == OP_HALT);
  assign is_legal = (is_ar && (ir[3:0] <= 4'd8)) || is_t;
  assign unused_ir_bit4 = ir[4];

  assign imem_addr = pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      ir           <= 16'd0;
      pc           <= '0;
      imem_req     <= 1'b0;
      ALUop        <= 4'b1111;
      regWrite     <= 1'b0;
      muxWriteReg  <= 1'b0;
      muxWriteData <= 1'b0;
      rd_addr      <= 3'd0;
      rs_addr      <= 3'd0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      wr_en        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          rd_addr      <= ir[10:8];
          rs_addr      <= ir[7:5];
          ALUop        <= is_ar ? ir[3:0] : 4'b1111;
          muxWriteReg  <= is_t;
          muxWriteData <= is_t;
          // Illegal words that are not trapped fall through with wr_en low (NOP).
          wr_en        <= is_legal;
          if (is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end
`ifdef ILLEGAL_TRAP_EN
          else if (!is_legal) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
            busy    <= 1'b0;
          end
`endif
          else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          regWrite <= wr_en;
          state    <= S_WB;
        end
        S_WB: begin
          regWrite <= 1'b0;
          pc       <= pc + 1'b1;
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
